// File: rtl/atm_keypad_frontend_pkg.sv
// Shared definitions for the ATM keypad front end.
//   - fe_state_e : front-end state encodings (driven out on fe_state)
//   - op_e       : operation codes carried on the request
//   - KEY_*      : keypad control key codes
//   - is_digit() : true for key codes 0-9
package atm_keypad_frontend_pkg;

    typedef enum logic [2:0] {
        S_ACC    = 3'd0,
        S_PIN    = 3'd1,
        S_OP     = 3'd2,
        S_AMT    = 3'd3,
        S_NEWPIN = 3'd4,
        S_REQ    = 3'd5
    } fe_state_e;

    typedef enum logic [2:0] {
        OP_NONE       = 3'd0,
        OP_BALANCE    = 3'd1,
        OP_WITHDRAW   = 3'd2,
        OP_DEPOSIT    = 3'd3,
        OP_CHANGE_PIN = 3'd4,
        OP_EXIT       = 3'd5
    } op_e;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    // Number of BCD digits in a PIN field.
    localparam int BCD_DIGITS = 4;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/atm_keypad_frontend_if.sv
// Request bus between the keypad front end and the ATM controller.
//   req_valid  : request pending (front end -> controller)
//   req_ready  : controller accepts the request (controller -> front end)
//   operation, acc_num, pin, newPin, amount : request fields, stable while
//                req_valid is high
// Modports: master = front end, slave = ATM controller.
interface atm_keypad_frontend_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] newPin;
    logic [15:0] amount;

    modport master (
        output req_valid, operation, acc_num, pin, newPin, amount,
        input  req_ready
    );

    modport slave (
        input  req_valid, operation, acc_num, pin, newPin, amount,
        output req_ready
    );

endinterface

// File: rtl/atm_keypad_frontend_bcd_field_entry.sv
// bcd_field_entry: 4-digit packed-BCD shift register with a digit counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the value and the counter (wins over load)
//   load     : shift digit in at the low nibble; ignored once full
//   digit    : BCD digit to shift in
//   value    : packed digits, first-entered digit ends up in [15:12]
//   full     : four digits have been entered
module bcd_field_entry
    import atm_keypad_frontend_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [3:0]  digit,
    output logic [15:0] value,
    output logic        full
);

    logic [15:0] value_q, value_d;
    logic [2:0]  cnt_q, cnt_d;

    assign full  = (cnt_q == 3'(BCD_DIGITS));
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (clr) begin
            value_d = '0;
            cnt_d   = '0;
        end else if (load && !full) begin
            value_d = {value_q[11:0], digit};
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/atm_keypad_frontend.sv
// atm_keypad_frontend: collects keypad strokes into one ATM request
// (account, PIN, operation, amount, new PIN) and presents it on a
// valid/ready bus. Account and PIN persist across operations until
// EXIT or CANCEL.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   key_valid, key_code : one-cycle key strobe and code (0-9, A ENTER,
//                         B CLEAR, C CANCEL, others ignored)
//   req_if (master)     : request bus, see atm_keypad_frontend_if
//   entry_err           : one-cycle pulse on a rejected key
//   fe_state            : current state for display
//   timeout             : one-cycle pulse on inactivity abort
// Optional feature: define ATM_TIMEOUT_EN to build the inactivity counter
// (TIMEOUT_CYCLES); otherwise timeout is constant 0.
module atm_keypad_frontend
    import atm_keypad_frontend_pkg::*;
#(
    parameter logic [15:0] MAX_AMOUNT     = 16'd9999,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    atm_keypad_frontend_if.master req_if,
    output logic                  entry_err,
    output logic [2:0]            fe_state,
    output logic                  timeout
);

    fe_state_e   state_q, state_d;
    logic [3:0]  acc_q, acc_d;
    logic        acc_ok_q, acc_ok_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] amt_q, amt_d;
    logic        req_valid_q, req_valid_d;
    logic        entry_err_q, entry_err_d;
    logic        timeout_q, timeout_d;

    logic        pin_clr, pin_ld, pin_full;
    logic        npin_clr, npin_ld, npin_full;
    logic [15:0] pin_val, npin_val;

    logic        key_digit, key_enter, key_clear, key_cancel;
    logic        handshake, expire, clear_all;
    logic [19:0] amt_calc;

    assign key_digit  = key_valid && is_digit(key_code);
    assign key_enter  = key_valid && (key_code == KEY_ENTER);
    assign key_clear  = key_valid && (key_code == KEY_CLEAR);
    assign key_cancel = key_valid && (key_code == KEY_CANCEL);
    assign handshake  = req_valid_q && req_if.req_ready;

    // Widened so an overflowing fifth digit can be detected and rejected.
    assign amt_calc = ({4'd0, amt_q} * 20'd10) + {16'd0, key_code};

    bcd_field_entry u_pin (
        .clk   (clk),
        .rst   (rst),
        .clr   (pin_clr),
        .load  (pin_ld),
        .digit (key_code),
        .value (pin_val),
        .full  (pin_full)
    );

    bcd_field_entry u_newpin (
        .clk   (clk),
        .rst   (rst),
        .clr   (npin_clr),
        .load  (npin_ld),
        .digit (key_code),
        .value (npin_val),
        .full  (npin_full)
    );

`ifdef ATM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hold;

    // Idle time only counts once a session has something worth aborting
    // and nothing is waiting on the controller. A key on the expiry cycle
    // holds the counter, so the key wins.
    assign tmo_hold  = key_valid || handshake || (state_q == S_REQ) ||
                       ((state_q == S_ACC) && !acc_ok_q);
    assign expire    = !tmo_hold && (tmo_cnt_q == TMO_LAST);
    assign tmo_cnt_d = (tmo_hold || expire) ? '0 : tmo_cnt_q + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_ok_d    = acc_ok_q;
        op_d        = op_q;
        amt_d       = amt_q;
        entry_err_d = 1'b0;
        timeout_d   = 1'b0;
        pin_clr     = 1'b0;
        pin_ld      = 1'b0;
        npin_clr    = 1'b0;
        npin_ld     = 1'b0;
        clear_all   = 1'b0;

        if (expire) begin
            clear_all = 1'b1;
            timeout_d = 1'b1;
        end else if (state_q == S_REQ) begin
            // Keys are dropped here; only the handshake moves us on.
            if (handshake) begin
                if (op_q == OP_EXIT) begin
                    clear_all = 1'b1;
                end else begin
                    op_d     = OP_NONE;
                    amt_d    = '0;
                    npin_clr = 1'b1;
                    state_d  = S_OP;
                end
            end
        end else if (key_cancel) begin
            clear_all = 1'b1;
        end else if (key_valid) begin
            unique case (state_q)
                S_ACC: begin
                    if (key_digit) begin
                        acc_d    = key_code;
                        acc_ok_d = 1'b1;
                    end else if (key_enter) begin
                        if (acc_ok_q) state_d = S_PIN;
                        else          entry_err_d = 1'b1;
                    end else if (key_clear) begin
                        acc_d    = '0;
                        acc_ok_d = 1'b0;
                    end
                end
                S_PIN: begin
                    if (key_digit) begin
                        if (pin_full) entry_err_d = 1'b1;
                        else          pin_ld = 1'b1;
                    end else if (key_enter) begin
                        if (pin_full) state_d = S_OP;
                        else          entry_err_d = 1'b1;
                    end else if (key_clear) begin
                        pin_clr = 1'b1;
                    end
                end
                S_OP: begin
                    if (key_digit) begin
                        if (key_code >= 4'd1 && key_code <= 4'd5) op_d = key_code[2:0];
                        else                                      entry_err_d = 1'b1;
                    end else if (key_enter) begin
                        case (op_q)
                            OP_BALANCE, OP_EXIT:     state_d = S_REQ;
                            OP_WITHDRAW, OP_DEPOSIT: state_d = S_AMT;
                            OP_CHANGE_PIN:           state_d = S_NEWPIN;
                            default:                 entry_err_d = 1'b1;
                        endcase
                    end else if (key_clear) begin
                        op_d = OP_NONE;
                    end
                end
                S_AMT: begin
                    if (key_digit) begin
                        if (amt_calc <= {4'd0, MAX_AMOUNT}) amt_d = amt_calc[15:0];
                        else                                entry_err_d = 1'b1;
                    end else if (key_enter) begin
                        if (amt_q == '0) entry_err_d = 1'b1;
                        else             state_d = S_REQ;
                    end else if (key_clear) begin
                        amt_d = '0;
                    end
                end
                S_NEWPIN: begin
                    if (key_digit) begin
                        if (npin_full) entry_err_d = 1'b1;
                        else           npin_ld = 1'b1;
                    end else if (key_enter) begin
                        if (npin_full) state_d = S_REQ;
                        else           entry_err_d = 1'b1;
                    end else if (key_clear) begin
                        npin_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (clear_all) begin
            state_d  = S_ACC;
            acc_d    = '0;
            acc_ok_d = 1'b0;
            op_d     = OP_NONE;
            amt_d    = '0;
            pin_clr  = 1'b1;
            npin_clr = 1'b1;
        end

        req_valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            acc_ok_q    <= 1'b0;
            op_q        <= '0;
            amt_q       <= '0;
            req_valid_q <= 1'b0;
            entry_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_ok_q    <= acc_ok_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            req_valid_q <= req_valid_d;
            entry_err_q <= entry_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign req_if.req_valid = req_valid_q;
    assign req_if.operation = op_q;
    assign req_if.acc_num   = acc_q;
    assign req_if.pin       = pin_val;
    assign req_if.newPin    = npin_val;
    assign req_if.amount    = amt_q;
    assign entry_err        = entry_err_q;
    assign fe_state         = state_q;
    assign timeout          = timeout_q;

endmodule

// File: doc/atm_keypad_frontend.md
Name: atm_keypad_frontend

Overview:
- Keypad-side initiator that collects user key strokes and builds one complete transaction request (account, PIN, operation, amount, new PIN) for the ATM controller.
- Presents each request on a valid/ready handshake and holds all fields stable until the request is accepted.
- Sits between the keypad scanner and the ATM controller. Owns the session: account and PIN persist across operations until EXIT or CANCEL.

Parameters:
- MAX_AMOUNT, 16'd9999, largest amount accepted in the amount field.
- TIMEOUT_CYCLES, 1000, inactivity limit in clk cycles; used only with ATM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- key_valid  in  1  one-cycle key strobe
- key_code  in  4  key value: 0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC CANCEL, others ignored
- req_valid  out  1  request pending
- req_ready  in  1  ATM controller accepts the request
- operation  out  3  operation code
- acc_num  out  4  account index, 0-9
- pin  out  16  PIN as 4 packed BCD digits, first-entered digit in [15:12]
- newPin  out  16  new PIN in the same packed BCD format
- amount  out  16  amount, binary
- entry_err  out  1  one-cycle pulse on a rejected key
- fe_state  out  3  current state, for display
- timeout  out  1  one-cycle pulse on inactivity abort

Behaviour:
- Reset: all outputs 0; fe_state = S_ACC; digit counters 0.
- States: S_ACC, S_PIN, S_OP, S_AMT, S_NEWPIN, S_REQ. One transition at most per key. Output registers update the cycle after key_valid.
- S_ACC:
  - A digit loads acc_num and sets acc_ok.
  - ENTER with acc_ok moves to S_PIN. ENTER without acc_ok pulses entry_err.
- S_PIN:
  - A digit shifts in: pin = {pin[11:0], d}; cnt++.
  - A digit when cnt == 4 is dropped and pulses entry_err.
  - ENTER with cnt == 4 moves to S_OP. ENTER otherwise pulses entry_err.
- S_OP:
  - Digits 1-5 load operation: BALANCE 1, WITHDRAW 2, DEPOSIT 3, CHANGE_PIN 4, EXIT 5.
  - Digits 0 and 6-9 pulse entry_err.
  - ENTER with no operation loaded pulses entry_err.
  - ENTER with BALANCE or EXIT goes to S_REQ; WITHDRAW or DEPOSIT goes to S_AMT; CHANGE_PIN goes to S_NEWPIN.
- S_AMT:
  - A digit computes amount*10 + d at 20-bit width. If the result is <= MAX_AMOUNT it is loaded; otherwise the digit is dropped and entry_err pulses.
  - ENTER with amount == 0 pulses entry_err; otherwise goes to S_REQ.
- S_NEWPIN: same digit rules as S_PIN, loading newPin. ENTER with 4 digits goes to S_REQ.
- CLEAR (S_ACC..S_NEWPIN): zeros the current field and its counter; no state change.
- CANCEL (S_ACC..S_NEWPIN): zeros all fields and goes to S_ACC.
- S_REQ:
  - req_valid = 1; operation, acc_num, pin, newPin and amount are held constant.
  - All keys are ignored, including CANCEL; a key arriving in the same cycle as the handshake is also dropped.
  - On req_valid && req_ready, req_valid drops the next cycle.
  - After a handshake with EXIT: all fields cleared, go to S_ACC.
  - After any other handshake: operation, amount and newPin cleared, acc_num and pin kept, go to S_OP.
- rst during any state, including S_REQ, forces the reset values the next cycle; a pending request is abandoned.
- entry_err and timeout never assert together.

Optional Feature:
- Macro ATM_TIMEOUT_EN.
- Defined:
  - A counter is cleared by key_valid, by the handshake, and while in S_REQ or in S_ACC with acc_ok == 0.
  - When the counter reaches TIMEOUT_CYCLES-1: all fields cleared, go to S_ACC, timeout pulses for one cycle.
  - If a key and expiry fall in the same cycle, the key wins and the counter clears.
- Not defined: no counter is built; timeout is tied to 0.

Decomposition:
- Shared definitions package:
  - operation codes (BALANCE, WITHDRAW, DEPOSIT, CHANGE_PIN, EXIT)
  - key codes (ENTER, CLEAR, CANCEL)
  - fe_state encodings
- Sub-module bcd_field_entry: a 4-digit shift register with counter, full flag, clear and load. Instantiated twice, for pin and newPin.

Test Plan:
- Balance: keys 3,ENTER,1,2,3,4,ENTER,1,ENTER -> req_valid with acc_num=3, pin=16'h1234, operation=1. req_ready pulse -> fe_state=S_OP, pin still 16'h1234.
- Withdraw: after login, keys 2,ENTER,2,5,0,ENTER -> amount=250 on request. Hold req_ready=0 for 10 cycles -> all fields stable. Assert req_ready -> amount returns to 0.
- Limits: in S_AMT keys 9,9,9,9,9 -> amount=9999 and entry_err on the 5th key. Keys ENTER at amount 0, and a 5th PIN digit -> entry_err, no state change.
- CANCEL and CLEAR: CANCEL in S_NEWPIN -> S_ACC with all fields 0. CLEAR after PIN digits 1,2 -> pin=0, then 4 fresh digits are accepted.
- EXIT and reset: EXIT request plus handshake -> S_ACC with acc_num=0, pin=0. rst asserted in S_REQ -> req_valid=0 on the next cycle.
- ATM_TIMEOUT_EN with TIMEOUT_CYCLES=20: idle in S_PIN -> timeout pulse after 20 cycles, then S_ACC. A key on the expiry cycle -> no timeout.
